// File: rtl/fp_result_pack_out.sv
// Output stage of the FP add/subtract unit: captures normalized result fields,
// classifies them (zero/overflow/underflow/normal) and holds the packed IEEE-754 word for the consumer.
module fp_result_pack_out #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          sign_i,
  input  logic [EW:0]   exp_i,
  input  logic          underflow_i,
  input  logic [SW:0]   sgf_i,
  input  logic          zero_flag_i,
  input  logic          ready_i,
  output logic          busy_o,
  output logic          valid_o,
  output logic [W-1:0]  final_result_o,
  output logic          overflow_flag_o,
  output logic          underflow_flag_o
);

  // Handshake: a word transfers on a rising edge where valid_o=1 and ready_i=1;
  // while valid_o=1 and ready_i=0 the word and flags are held unchanged.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLASSIFY = 2'd1,
    S_PACK     = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_OVF  = 2'd1,
    CLS_UNF  = 2'd2,
    CLS_NORM = 2'd3
  } cls_t;

  state_t         state_q, state_d;
  cls_t           cls_q, cls_d;
  logic           sign_q, sign_d;
  logic [EW:0]    exp_q, exp_d;
  logic           unf_q, unf_d;
  logic [SW:0]    sgf_q, sgf_d;
  logic           zero_q, zero_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   result_q, result_d;
  logic           ovf_flag_q, ovf_flag_d;
  logic           unf_flag_q, unf_flag_d;
  logic           capture;
  logic           unused_hidden;

  // The hidden bit travels with the significand but is never stored in the word.
  assign unused_hidden = sgf_q[SW];

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    unf_d      = unf_q;
    sgf_d      = sgf_q;
    zero_d     = zero_q;
    valid_d    = valid_q;
    result_d   = result_q;
    ovf_flag_d = ovf_flag_q;
    unf_flag_d = unf_flag_q;
    capture    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          capture = 1'b1;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        // Priority: exact zero, then overflow, then underflow.
        if (zero_q)
          cls_d = CLS_ZERO;
        else if (exp_q[EW] || (&exp_q[EW-1:0]))
          cls_d = CLS_OVF;
        else if (unf_q || (exp_q == '0))
          cls_d = CLS_UNF;
        else
          cls_d = CLS_NORM;
        state_d = S_PACK;
      end
      S_PACK: begin
        valid_d    = 1'b1;
        ovf_flag_d = 1'b0;
        unf_flag_d = 1'b0;
        case (cls_q)
          CLS_ZERO: result_d = '0;
          CLS_OVF: begin
            result_d   = {sign_q, {EW{1'b1}}, {SW{1'b0}}};
            ovf_flag_d = 1'b1;
          end
          CLS_UNF: begin
            result_d   = {sign_q, {EW{1'b0}}, {SW{1'b0}}};
            unf_flag_d = 1'b1;
          end
          default: result_d = {sign_q, exp_q[EW-1:0], sgf_q[SW-1:0]};
        endcase
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ready_i) begin
          valid_d = 1'b0;
          if (start_i) begin
            capture = 1'b1;
            state_d = S_CLASSIFY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      sign_d = sign_i;
      exp_d  = exp_i;
      unf_d  = underflow_i;
      sgf_d  = sgf_i;
      zero_d = zero_flag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cls_q      <= CLS_ZERO;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      unf_q      <= 1'b0;
      sgf_q      <= '0;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      ovf_flag_q <= 1'b0;
      unf_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      unf_q      <= unf_d;
      sgf_q      <= sgf_d;
      zero_q     <= zero_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      ovf_flag_q <= ovf_flag_d;
      unf_flag_q <= unf_flag_d;
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign valid_o          = valid_q;
  assign final_result_o   = result_q;
  assign overflow_flag_o  = ovf_flag_q;
  assign underflow_flag_o = unf_flag_q;

endmodule

// File: tb/tb_fp_result_pack_out.sv
// Bench for fp_result_pack_out: directed spec vectors, backpressure, reset and
// back-to-back cases, then random fields checked against an arithmetic reference model.
module tb_fp_result_pack_out;

  localparam int W  = 32;
  localparam int EW = 8;
  localparam int SW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          sign_i;
  logic [EW:0]   exp_i;
  logic          underflow_i;
  logic [SW:0]   sgf_i;
  logic          zero_flag_i;
  logic          ready_i;
  logic          busy_o;
  logic          valid_o;
  logic [W-1:0]  final_result_o;
  logic          overflow_flag_o;
  logic          underflow_flag_o;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];

  fp_result_pack_out #(.W(W), .EW(EW), .SW(SW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .sign_i           (sign_i),
    .exp_i            (exp_i),
    .underflow_i      (underflow_i),
    .sgf_i            (sgf_i),
    .zero_flag_i      (zero_flag_i),
    .ready_i          (ready_i),
    .busy_o           (busy_o),
    .valid_o          (valid_o),
    .final_result_o   (final_result_o),
    .overflow_flag_o  (overflow_flag_o),
    .underflow_flag_o (underflow_flag_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference: {overflow_flag, underflow_flag, word} from plain arithmetic on field values.
  function automatic logic [W+1:0] model(input logic s, input logic [EW:0] e, input logic u,
                                         input logic [SW:0] g, input logic z);
    longint unsigned ev, top, word, sgn;
    top = (64'd1 << EW) - 64'd1;
    ev  = 64'(e);
    sgn = s ? (64'd1 << (W-1)) : 64'd0;
    if (z) return '0;
    if (ev >= top) begin
      word = sgn + top * (64'd1 << SW);
      return {2'b10, word[W-1:0]};
    end
    if (u || ev == 0) begin
      word = sgn;
      return {2'b01, word[W-1:0]};
    end
    word = sgn + ev * (64'd1 << SW) + (64'(g) % (64'd1 << SW));
    return {2'b00, word[W-1:0]};
  endfunction

  function automatic logic [W+1:0] observed();
    return {overflow_flag_o, underflow_flag_o, final_result_o};
  endfunction

  task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic s, input logic [EW:0] e, input logic u,
                       input logic [SW:0] g, input logic z);
    sign_i      = s;
    exp_i       = e;
    underflow_i = u;
    sgf_i       = g;
    zero_flag_i = z;
  endtask

  task automatic check_result(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, {{(W+1){1'b0}}, 1'b1}, '0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_word"}, observed(), e);
    end
  endtask

  // One request from IDLE with ready_i high; checks latency, pulse width and hold-after.
  task automatic do_txn(input string tag, input logic s, input logic [EW:0] e, input logic u,
                        input logic [SW:0] g, input logic z, input logic [W+1:0] expv);
    logic [W+1:0] snap;
    @(negedge clk);
    drive(s, e, u, g, z);
    start_i = 1'b1;
    ready_i = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start_i = 1'b0;
    check({tag, "_busy1"}, W'(busy_o), W'(1));
    check({tag, "_valid_c"}, W'(valid_o), W'(0));
    @(negedge clk);
    check({tag, "_valid_p"}, W'(valid_o), W'(0));
    @(negedge clk);
    check({tag, "_valid_h"}, W'(valid_o), W'(1));
    snap = exp_q.size() > 0 ? exp_q[0] : '0;
    check_result(tag);
    @(negedge clk);
    check({tag, "_valid_end"}, W'(valid_o), W'(0));
    check({tag, "_busy_end"}, W'(busy_o), W'(0));
    check({tag, "_kept"}, observed(), snap);
  endtask

  initial begin
    logic [W+1:0] held;
    rst = 1'b1; start_i = 1'b0; ready_i = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy_o), W'(0));
    check("rst_valid", W'(valid_o), W'(0));
    check("rst_word", observed(), '0);
    rst = 1'b0;

    // Directed vectors with independently known answers
    do_txn("norm", 1'b0, 9'h07F, 1'b0, 24'hC00000, 1'b0, {2'b00, 32'h3FC00000});
    do_txn("ovf_carry", 1'b1, 9'h100, 1'b0, 24'h800000, 1'b0, {2'b10, 32'hFF800000});
    do_txn("ovf_ones", 1'b0, 9'h0FF, 1'b0, 24'hABCDEF, 1'b0, {2'b10, 32'h7F800000});
    do_txn("unf_flag", 1'b1, 9'h005, 1'b1, 24'h912345, 1'b0, {2'b01, 32'h80000000});
    do_txn("unf_exp0", 1'b0, 9'h000, 1'b0, 24'h812345, 1'b0, {2'b01, 32'h00000000});
    do_txn("zero_wins", 1'b1, 9'h1FF, 1'b1, 24'hFFFFFF, 1'b1, {2'b00, 32'h00000000});
    do_txn("norm_max", 1'b1, 9'h0FE, 1'b0, 24'hFFFFFF, 1'b0, {2'b00, 32'hFF7FFFFF});
    do_txn("norm_min", 1'b0, 9'h001, 1'b0, 24'h800001, 1'b0, {2'b00, 32'h00800001});

    // Backpressure: stall in HOLD, extra start pulses must be ignored
    @(negedge clk);
    drive(1'b1, 9'h080, 1'b0, 24'hA00000, 1'b0);
    start_i = 1'b1; ready_i = 1'b0;
    exp_q.push_back({2'b00, 32'hC0200000});
    @(negedge clk); start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid0", W'(valid_o), W'(1));
    held = observed();
    check_result("bp_first");
    for (int i = 0; i < 5; i++) begin
      start_i = i[0];
      drive(1'b0, 9'h100, 1'b0, 24'h800000, 1'b1);
      @(negedge clk);
      check("bp_stall_valid", W'(valid_o), W'(1));
      check("bp_stall_word", observed(), held);
    end
    drive(1'b0, 9'h003, 1'b0, 24'h812345, 1'b0);
    start_i = 1'b1; ready_i = 1'b1;
    exp_q.push_back({2'b00, 32'h01812345});
    @(negedge clk); start_i = 1'b0;
    check("bp_b2b_valid_c", W'(valid_o), W'(0));
    check("bp_b2b_busy", W'(busy_o), W'(1));
    @(negedge clk);
    check("bp_b2b_valid_p", W'(valid_o), W'(0));
    @(negedge clk);
    check("bp_b2b_valid_h", W'(valid_o), W'(1));
    check_result("bp_second");
    @(negedge clk);

    // Reset while in PACK discards the result
    drive(1'b0, 9'h0FF, 1'b0, 24'h800000, 1'b0);
    start_i = 1'b1; ready_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_pack_busy", W'(busy_o), W'(0));
    check("rst_pack_valid", W'(valid_o), W'(0));
    check("rst_pack_word", observed(), '0);
    @(negedge clk);
    check("rst_pack_novalid", W'(valid_o), W'(0));
    do_txn("after_rst", 1'b0, 9'h07F, 1'b0, 24'hC00000, 1'b0, {2'b00, 32'h3FC00000});

    // Reset coinciding with ready in HOLD: no transfer, outputs cleared
    drive(1'b1, 9'h100, 1'b0, 24'h800000, 1'b0);
    start_i = 1'b1; ready_i = 1'b0;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rh_valid", W'(valid_o), W'(1));
    rst = 1'b1; ready_i = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rh_cleared", observed(), '0);
    check("rh_valid0", W'(valid_o), W'(0));

    // Back-to-back with start held high: one result every 3 cycles
    @(negedge clk);
    drive(1'b0, 9'h085, 1'b0, 24'hF00000, 1'b0);
    start_i = 1'b1; ready_i = 1'b1;
    exp_q.push_back(model(1'b0, 9'h085, 1'b0, 24'hF00000, 1'b0));
    @(negedge clk);
    drive(1'b1, 9'h001, 1'b1, 24'h800000, 1'b0);
    exp_q.push_back(model(1'b1, 9'h001, 1'b1, 24'h800000, 1'b0));
    @(negedge clk);
    @(negedge clk);
    check("b2b_a_valid", W'(valid_o), W'(1));
    check_result("b2b_a");
    @(negedge clk); start_i = 1'b0;
    check("b2b_gap", W'(valid_o), W'(0));
    @(negedge clk);
    @(negedge clk);
    check("b2b_b_valid", W'(valid_o), W'(1));
    check_result("b2b_b");
    @(negedge clk);

    // Random fields against the reference model
    for (int n = 0; n < 40; n++) begin
      logic s, u, z;
      logic [EW:0] e;
      logic [SW:0] g;
      s = 1'($urandom_range(0, 1));
      u = ($urandom_range(0, 5) == 0);
      z = ($urandom_range(0, 7) == 0);
      g = (SW+1)'($urandom());
      case ($urandom_range(0, 3))
        0: e = (EW+1)'($urandom_range(0, 511));
        1: e = (EW+1)'($urandom_range(254, 256));
        2: e = (EW+1)'($urandom_range(0, 1));
        default: e = (EW+1)'($urandom_range(1, 254));
      endcase
      do_txn("rand", s, e, u, g, z, model(s, e, u, g, z));
    end

    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
